hack_instr_encoder: RTL and testbench

Streaming encoder that packs Hack instruction fields (A-constant, or a/comp/dest/jump) into 16-bit instruction words and writes them, with sequential addresses, into instruction ROM.
- It is the write-side counterpart of the CPU's instruction decoder: the decoder unpacks words fetched from ROM, and this block produces those words during program load.
- It sits between the host/loader field stream and the ROM write port, with valid/ready handshakes on both sides.

---
 rtl/hack_pkg.sv | 43 ++++
 rtl/hack_comp_check.sv | 12 +
 rtl/hack_instr_encoder.sv | 142 ++++++++++++++
 tb/tb_hack_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack encoding constants, comp-code table and encoder FSM state type.
package hack_pkg;

  localparam logic       A_PREFIX = 1'b0;
  localparam logic [2:0] C_PREFIX = 3'b111;

  // Entries before COMP_A_FIRST never touch A; the rest also exist as M forms (a=1).
  localparam int COMP_N       = 18;
  localparam int COMP_A_FIRST = 8;
  localparam logic [5:0] COMP_TABLE [COMP_N] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100,
    6'b001101, 6'b001111, 6'b011111, 6'b001110,
    6'b110000, 6'b110001, 6'b110011, 6'b110111,
    6'b110010, 6'b000010, 6'b010011, 6'b000111,
    6'b000000, 6'b010101
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } enc_state_t;

  function automatic logic [15:0] encode_a(input logic [14:0] value);
    return {A_PREFIX, value};
  endfunction

  function automatic logic [15:0] encode_c(input logic a, input logic [5:0] comp,
                                           input logic [2:0] dest, input logic [2:0] jump);
    return {C_PREFIX, a, comp, dest, jump};
  endfunction

  function automatic logic comp_legal(input logic a, input logic [5:0] comp);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < COMP_N; i++) begin
      if ((!a || i >= COMP_A_FIRST) && COMP_TABLE[i] == comp) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/hack_comp_check.sv
// Combinational legality check of a C-instruction comp code against the Hack table.
module hack_comp_check
  import hack_pkg::*;
(
  input  logic       a,
  input  logic [5:0] comp,
  output logic       legal
);

  assign legal = comp_legal(a, comp);

endmodule

// File: rtl/hack_instr_encoder.sv
// Streams Hack instruction fields into 16-bit words written to ROM at sequential addresses.
// Define HACK_ENC_CHECK_EN to drop C-records with illegal comp codes and expose `illegal`.
module hack_instr_encoder
  import hack_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_c,
  input  logic [14:0]       in_value,
  input  logic              in_a,
  input  logic [5:0]        in_comp,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_jump,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
`ifdef HACK_ENC_CHECK_EN
  ,
  output logic              illegal
`endif
);

  // The address counter is one bit wider so it can sit at DEPTH without wrapping.
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W+1)'(1);

  enc_state_t      state, state_nxt;
  logic [ADDR_W:0] addr;
  logic            hs, accept, full, legal, write, go;

  assign hs     = out_valid && out_ready;
  assign accept = in_valid && in_ready;
  assign full   = (addr == DEPTH_CNT);
  assign go     = start && (state == IDLE || state == ERR);

`ifdef HACK_ENC_CHECK_EN
  logic comp_ok;

  hack_comp_check u_comp_check (
    .a     (in_a),
    .comp  (in_comp),
    .legal (comp_ok)
  );

  assign legal = !in_is_c || comp_ok;
`else
  assign legal = 1'b1;
`endif

  assign write = accept && !full && legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          if (full)         state_nxt = ERR;
          else if (in_last) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (!out_valid || out_ready) state_nxt = IDLE;
      ERR:     if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = out_valid;
    case (state)
      RUN: begin
        in_ready = !out_valid || out_ready;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Single output register: a handshake and a new accept in one cycle reload it with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_addr  <= '0;
      addr      <= '0;
    end else if (go) begin
      addr <= '0;
      if (hs) out_valid <= 1'b0;
    end else if (write) begin
      out_valid <= 1'b1;
      out_word  <= in_is_c ? encode_c(in_a, in_comp, in_dest, in_jump) : encode_a(in_value);
      out_addr  <= addr[ADDR_W-1:0];
      addr      <= addr + ONE_CNT;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == DRAIN) && (!out_valid || out_ready);
      if (go) begin
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (hs)            word_count <= word_count + ONE_CNT;
        if (accept && full) overflow  <= 1'b1;
      end
    end
  end

`ifdef HACK_ENC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= accept && !full && !legal;
  end
`endif

endmodule

// File: tb/tb_hack_instr_encoder.sv
// Scoreboard bench for hack_instr_encoder: stimulus tasks push expected ROM writes,
// a falling-edge monitor pops and compares every output handshake.
module tb_hack_instr_encoder;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 6;

  typedef struct {
    logic [15:0] word;
    int          addr;
    bit          last;
  } exp_t;

  exp_t sb[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_is_c;
  logic [14:0]       in_value;
  logic              in_a;
  logic [5:0]        in_comp;
  logic [2:0]        in_dest;
  logic [2:0]        in_jump;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
`ifdef HACK_ENC_CHECK_EN
  logic              illegal;
`endif

  int compared   = 0;
  int mismatched = 0;
  int exp_addr   = 0;
  bit exp_overflow = 1'b0;
  int ready_mode = 0;
  bit done_due   = 1'b0;

  always #5 clk = ~clk;

  hack_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_c    (in_is_c),
    .in_value   (in_value),
    .in_a       (in_a),
    .in_comp    (in_comp),
    .in_dest    (in_dest),
    .in_jump    (in_jump),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_addr   (out_addr),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
`ifdef HACK_ENC_CHECK_EN
    ,
    .illegal    (illegal)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Reference word from the Hack format: A = plain constant, C = 0xE000 + weighted fields.
  function automatic logic [15:0] modelWord(input bit is_c, input int value, input int a,
                                            input int comp, input int dest, input int jump);
    int w;
    if (!is_c) w = value;
    else       w = 'hE000 + a * 4096 + comp * 64 + dest * 8 + jump;
    return 16'(w);
  endfunction

`ifdef HACK_ENC_CHECK_EN
  function automatic bit modelLegal(input bit is_c, input int a, input int comp);
    int d_only [8]  = '{42, 63, 58, 12, 13, 15, 31, 14};
    int am_form [10] = '{48, 49, 51, 55, 50, 2, 19, 7, 0, 21};
    if (!is_c) return 1'b1;
    foreach (am_form[i]) if (am_form[i] == comp) return 1'b1;
    if (a == 0) foreach (d_only[i]) if (d_only[i] == comp) return 1'b1;
    return 1'b0;
  endfunction
`endif

  // Entry and exit of every stimulus task: 1 time unit after a rising edge.
  task automatic pulseStart(input bit model_reset);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (model_reset) begin
      exp_addr     = 0;
      exp_overflow = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit is_c, input int value, input int a, input int comp,
                               input int dest, input int jump, input bit last, input int lit = -1);
    bit   accepted;
    bit   legal;
    exp_t e;
    accepted = 1'b0;
    legal    = 1'b1;
`ifdef HACK_ENC_CHECK_EN
    legal = modelLegal(is_c, a, comp);
`endif
    in_is_c  = is_c;
    in_value = 15'(value);
    in_a     = 1'(a);
    in_comp  = 6'(comp);
    in_dest  = 3'(dest);
    in_jump  = 3'(jump);
    in_last  = last;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && !accepted; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        if (exp_addr == DEPTH) begin
          exp_overflow = 1'b1;
        end else if (legal) begin
          e.word = (lit >= 0) ? 16'(lit) : modelWord(is_c, value, a, comp, dest, jump);
          e.addr = exp_addr;
          e.last = last;
          sb.push_back(e);
          exp_addr++;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!accepted) failNow("accept_timeout");
  endtask

  task automatic sendRandom(input bit last);
    bit is_c;
    is_c = 1'($urandom % 2);
`ifdef HACK_ENC_CHECK_EN
    if (last) is_c = 1'b0;
`endif
    applyStimulus(is_c, int'($urandom % 32768), int'($urandom % 2), int'($urandom % 64),
                  int'($urandom % 8), int'($urandom % 8), last);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) failNow("done_timeout");
    checkOutput("word_count", 32'(word_count), 32'(exp_addr));
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_word", 32'(out_word), 32'd0);
    checkOutput("rst_out_addr", 32'(out_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
  endtask

  // Backpressure source: mode 0 always ready, 1 random, 2 stalled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold/done behaviour.
  initial begin : monitor
    exp_t              e;
    logic [15:0]       held_word;
    logic [ADDR_W-1:0] held_addr;
    bit                holding;
    holding   = 1'b0;
    held_word = '0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        holding  = 1'b0;
        done_due = 1'b0;
      end else begin
        checkOutput("done_pulse", 32'(done), 32'(done_due));
        done_due = 1'b0;
        if (holding) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_word", 32'(out_word), 32'(held_word));
          checkOutput("hold_addr", 32'(out_addr), 32'(held_addr));
        end
        holding = 1'b0;
        if (out_valid && !out_ready) begin
          checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
          holding   = 1'b1;
          held_word = out_word;
          held_addr = out_addr;
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            failNow("unexpected_write");
          end else begin
            e = sb.pop_front();
            checkOutput("out_word", 32'(out_word), 32'(e.word));
            checkOutput("out_addr", 32'(out_addr), 32'(e.addr));
            done_due = e.last;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout at %0t", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int len;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_is_c  = 1'b0;
    in_value = '0;
    in_a     = 1'b0;
    in_comp  = '0;
    in_dest  = '0;
    in_jump  = '0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single A-instruction load");
    pulseStart(1'b1);
    applyStimulus(1'b0, 21, 0, 0, 0, 0, 1'b1, 'h0015);
    waitDone();

    $display("[TB] two C-instructions with a stray start mid-load");
    pulseStart(1'b1);
    applyStimulus(1'b1, 0, 1, 'b110111, 'b001, 'b000, 1'b0, 'hFDC8);
    pulseStart(1'b0);
    applyStimulus(1'b1, 0, 0, 'b001100, 'b000, 'b001, 1'b1, 'hE301);
    waitDone();

    $display("[TB] four records under a three-cycle stall");
    ready_mode = 2;
    pulseStart(1'b1);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 ready_mode = 0;
      end
    join_none
    for (int i = 0; i < 4; i++) sendRandom(i == 3);
    waitDone();

    $display("[TB] overflow past DEPTH");
    ready_mode = 0;
    pulseStart(1'b1);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1'b0, int'($urandom % 32768), 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("overflow_set", 32'(overflow), 32'(exp_overflow));
    checkOutput("err_in_ready", 32'(in_ready), 32'd0);
    checkOutput("err_busy", 32'(busy), 32'd0);
    checkOutput("err_word_count", 32'(word_count), 32'(DEPTH));
    @(posedge clk); #1;
    pulseStart(1'b1);
    @(negedge clk);
    checkOutput("overflow_cleared", 32'(overflow), 32'(exp_overflow));
    @(posedge clk); #1;
    applyStimulus(1'b0, 7, 0, 0, 0, 0, 1'b1, 'h0007);
    waitDone();

    $display("[TB] reset during a stalled load");
    ready_mode = 2;
    pulseStart(1'b1);
    sendRandom(1'b0);
    @(negedge clk);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    sb.delete();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pulseStart(1'b1);
    for (int i = 0; i < 3; i++) sendRandom(i == 2);
    waitDone();

`ifdef HACK_ENC_CHECK_EN
    $display("[TB] illegal comp code is dropped");
    pulseStart(1'b1);
    applyStimulus(1'b1, 0, 1, 'b001100, 0, 0, 1'b0);
    checkOutput("illegal_pulse", 32'(illegal), 32'd1);
    applyStimulus(1'b0, 5, 0, 0, 0, 0, 1'b1, 'h0005);
    waitDone();
`endif

    $display("[TB] randomized programs with random backpressure");
    ready_mode = 1;
    for (int p = 0; p < 25; p++) begin
      len = int'($urandom_range(1, DEPTH));
      pulseStart(1'b1);
      for (int i = 0; i < len; i++) sendRandom(i == len - 1);
      waitDone();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
